// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: one outstanding SRAM request at a time, a held
// instruction slot towards decode, redirect handling and a fetch-timeout flag.
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt
);

  localparam int             WW  = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0]  TMO = WW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc, pc_nxt;
  logic          drop, drop_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt, wait_inc;
  logic [31:0]   inst_nxt, inst_pc_nxt, cnt_nxt;
  logic          err_nxt;

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    drop_nxt    = drop;
    wait_nxt    = wait_cnt;
    inst_nxt    = inst;
    inst_pc_nxt = inst_pc;
    err_nxt     = fetch_err;
    cnt_nxt     = fetch_cnt;
    mem_req     = 1'b0;
    mem_addr    = pc;
    inst_valid  = 1'b0;
    wait_inc    = (wait_cnt == TMO) ? wait_cnt : wait_cnt + 1'b1;

    unique case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        // The request still goes out with the old pc; a redirect only marks its data stale.
        mem_req   = 1'b1;
        state_nxt = WAIT;
        drop_nxt  = redirect_valid;
        wait_nxt  = '0;
      end
      WAIT: begin
        wait_nxt = wait_inc;
        if (wait_inc == TMO) err_nxt = 1'b1;
        if (redirect_valid) begin
          drop_nxt = 1'b1;
          if (mem_rvalid) begin
            state_nxt = REQ;
            drop_nxt  = 1'b0;
          end
        end else if (mem_rvalid) begin
          drop_nxt = 1'b0;
          if (drop) begin
            state_nxt = REQ;
          end else begin
            state_nxt   = HOLD;
            inst_nxt    = mem_rdata;
            inst_pc_nxt = pc;
          end
        end
      end
      HOLD: begin
        inst_valid = 1'b1;
        if (redirect_valid) begin
          state_nxt = REQ;
        end else if (inst_ready) begin
          state_nxt = REQ;
          pc_nxt    = pc + 32'd4;
          cnt_nxt   = fetch_cnt + 32'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Redirect outranks everything, including a same-cycle transfer.
    if (redirect_valid) pc_nxt = {redirect_pc[31:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      wait_cnt  <= '0;
      inst      <= '0;
      inst_pc   <= '0;
      fetch_err <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      drop      <= drop_nxt;
      wait_cnt  <= wait_nxt;
      inst      <= inst_nxt;
      inst_pc   <= inst_pc_nxt;
      fetch_err <= err_nxt;
      fetch_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: SRAM responder plus program-counter model feeding a
// scoreboard, with directed latency/redirect/timeout scenarios and a random phase.
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] K      = 32'h5A5A_5A5A;

  logic        clk = 1'b0, rst = 1'b1;
  logic        redirect_valid = 1'b0, mem_rvalid = 1'b0, inst_ready = 1'b0;
  logic [31:0] redirect_pc = '0, mem_rdata = '0;
  logic        mem_req, inst_valid, fetch_err;
  logic [31:0] mem_addr, inst, inst_pc, fetch_cnt;

  ifu_fetch_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc),
    .fetch_err(fetch_err), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] cnt;
  } exp_inst_t;

  int          n_chk = 0, n_fail = 0;
  logic [31:0] addr_q[$];
  exp_inst_t   inst_q[$];

  // program-counter model and stimulus knobs
  logic [31:0] cur_pc = RST_PC, held_pc = '0, exp_cnt = '0, resp_addr = '0, force_tgt = '0;
  logic        addr_pending = 1'b0;
  int          cyc = 0, resp_due = -1, redir_pct = 0;
  logic [1:0]  ready_mode = 2'd1;
  logic        lat_rand = 1'b0, spurious = 1'b0, sram_never = 1'b0;
  logic        force_redir = 1'b0, force_on_hold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: react to DUT outputs, drive SRAM/redirect/ready, update the model.
  task automatic step();
    logic        req_now, hold_now, rv, rdv, rdy;
    logic [31:0] rd, tgt;
    @(posedge clk); #1;
    cyc++;
    if (rst) begin
      redirect_valid = 1'b0; inst_ready = 1'b0; mem_rvalid = 1'b0;
      return;
    end
    req_now  = mem_req;
    hold_now = inst_valid;
    if (req_now)  addr_pending = 1'b0;
    if (hold_now) held_pc = cur_pc;

    rv = 1'b0; rd = $urandom;
    if (resp_due == cyc) begin
      rv = 1'b1; rd = resp_addr ^ K; resp_due = -1;
    end else if (spurious && (req_now || hold_now) && $urandom_range(0, 3) == 0) begin
      rv = 1'b1;
    end
    if (req_now && !sram_never) begin
      resp_addr = mem_addr;
      resp_due  = cyc + (lat_rand ? int'($urandom_range(1, 4)) : 2);
    end

    rdv = 1'b0; tgt = $urandom;
    if (force_redir) begin
      if (!force_on_hold || hold_now) begin
        rdv = 1'b1; tgt = force_tgt; force_redir = 1'b0;
      end
    end else if (redir_pct != 0 && int'($urandom_range(0, 99)) < redir_pct) begin
      rdv = 1'b1;
    end
    rdy = (ready_mode == 2'd2) ? 1'($urandom_range(0, 1)) : ready_mode[0];

    redirect_valid = rdv; redirect_pc = tgt; inst_ready = rdy;
    mem_rvalid = rv; mem_rdata = rd;

    if (rdv) begin
      cur_pc = {tgt[31:2], 2'b00};
      if (addr_pending) addr_q[addr_q.size()-1] = cur_pc;
      else addr_q.push_back(cur_pc);
      addr_pending = 1'b1;
    end else if (hold_now && rdy) begin
      inst_q.push_back('{pc: cur_pc, data: cur_pc ^ K, cnt: exp_cnt});
      exp_cnt = exp_cnt + 32'd1;
      cur_pc  = cur_pc + 32'd4;
      addr_q.push_back(cur_pc);
      addr_pending = 1'b1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    addr_q.delete(); inst_q.delete();
    cur_pc = RST_PC; exp_cnt = '0; resp_due = -1;
    addr_q.push_back(RST_PC); addr_pending = 1'b1;
    rst = 1'b0;
    check("rst_mem_req", mem_req, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_fetch_err", fetch_err, 0);
    check("rst_fetch_cnt", fetch_cnt, 0);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    step();
    while (!mem_req && n < 30) begin step(); n++; end
    check({name, "_req_seen"}, mem_req, 1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    step();
    while (!inst_valid && n < 30) begin step(); n++; end
    check({name, "_valid_seen"}, inst_valid, 1);
  endtask

  // Scoreboard monitor
  initial begin
    logic [31:0] a;
    exp_inst_t   e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_req) begin
          check("req_expected", 32'(addr_q.size() != 0), 1);
          if (addr_q.size() != 0) begin
            a = addr_q.pop_front();
            check("mem_addr", mem_addr, a);
          end
        end
        if (inst_valid) begin
          check("held_pc", inst_pc, held_pc);
          check("held_inst", inst, held_pc ^ K);
        end
        if (inst_valid && inst_ready && !redirect_valid) begin
          check("xfer_expected", 32'(inst_q.size() != 0), 1);
          if (inst_q.size() != 0) begin
            e = inst_q.pop_front();
            check("xfer_pc", inst_pc, e.pc);
            check("xfer_inst", inst, e.data);
            check("xfer_cnt", fetch_cnt, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] hp, cnt0;
    logic        bad;
    int          n;

    // Reset, first request in the second cycle, one instruction per 4 cycles
    do_reset(3);
    step();
    check("d1_first_req", mem_req, 1);
    check("d1_first_addr", mem_addr, RST_PC);
    for (int i = 1; i < 12; i++) begin
      step();
      check("d1_req_cadence", mem_req, 32'(i % 4 == 0));
      check("d1_valid_cadence", inst_valid, 32'(i % 4 == 3));
      if (i % 4 == 0) check("d1_seq_addr", mem_addr, RST_PC + 32'(i));
    end
    step();
    check("d1_fetch_cnt", fetch_cnt, 3);

    // Stall in HOLD for 10 cycles, then accept
    ready_mode = 2'd0;
    wait_valid("d2");
    hp = cur_pc; bad = 1'b0;
    repeat (10) begin
      step();
      if (!inst_valid || mem_req || inst !== (hp ^ K) || inst_pc !== hp) bad = 1'b1;
    end
    check("d2_hold_stable", bad, 0);
    ready_mode = 2'd1;
    wait_req("d2");
    check("d2_next_addr", mem_addr, hp + 32'd4);

    // Redirect during WAIT: returned data dropped, misaligned target aligned
    wait_req("d3");
    force_redir = 1'b1; force_on_hold = 1'b0; force_tgt = 32'h8000_0102;
    cnt0 = exp_cnt; bad = 1'b0; n = 0;
    step(); bad |= inst_valid;
    while (!mem_req && n < 20) begin step(); bad |= inst_valid; n++; end
    check("d3_no_valid", bad, 0);
    check("d3_next_addr", mem_addr, 32'h8000_0100);
    check("d3_fetch_cnt", fetch_cnt, cnt0);

    // Redirect together with inst_ready in HOLD: no transfer
    force_redir = 1'b1; force_on_hold = 1'b1; force_tgt = 32'h0000_1000;
    cnt0 = exp_cnt;
    wait_req("d4");
    check("d4_redirect_fired", force_redir, 0);
    check("d4_next_addr", mem_addr, 32'h0000_1000);
    check("d4_fetch_cnt", fetch_cnt, cnt0);

    // Address wrap at the top of the address space
    force_redir = 1'b1; force_on_hold = 1'b0; force_tgt = 32'hFFFF_FFFC;
    wait_req("d5a");
    check("d5_top_addr", mem_addr, 32'hFFFF_FFFC);
    wait_req("d5b");
    check("d5_wrap_addr", mem_addr, 32'h0000_0000);
    check("d5_fetch_cnt", fetch_cnt, cnt0 + 32'd1);

    // Random traffic: ready, redirects, SRAM latency, stray rvalid
    ready_mode = 2'd2; redir_pct = 8; lat_rand = 1'b1; spurious = 1'b1;
    repeat (3000) step();
    redir_pct = 0; lat_rand = 1'b0; spurious = 1'b0; ready_mode = 2'd0;
    repeat (10) step();
    check("rnd_fetch_cnt", fetch_cnt, exp_cnt);
    check("rnd_no_err", fetch_err, 0);
    check("rnd_inst_q_drained", 32'(inst_q.size()), 0);

    // SRAM silent: timeout after 16 WAIT cycles, sticky until reset
    ready_mode = 2'd1; sram_never = 1'b1;
    wait_req("d7");
    for (int i = 1; i <= 17; i++) begin
      step();
      if (i == 16) check("d7_err_before", fetch_err, 0);
      if (i == 17) check("d7_err_set", fetch_err, 1);
    end
    bad = 1'b0;
    repeat (20) begin
      step();
      if (!fetch_err || mem_req || inst_valid) bad = 1'b1;
    end
    check("d7_err_sticky", bad, 0);
    do_reset(2);
    sram_never = 1'b0;
    step();
    check("d7_restart_req", mem_req, 1);
    check("d7_restart_addr", mem_addr, RST_PC);
    repeat (8) step();
    check("d7_restart_cnt", fetch_cnt, 2);
    check("end_inst_q_drained", 32'(inst_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
